fir_decim: RTL and testbench

FIR_DECIM -- requirements
Module: fir_decim

---
 rtl/fir_decim_pkg.sv | 11 +
 rtl/fir_decim_skid.sv | 72 +++++++
 rtl/fir_decim.sv | 82 ++++++++
 tb/tb_fir_decim.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_decim_pkg.sv
// Shared helpers for the FIR decimator: phase-counter width and FIFO occupancy type.
package fir_decim_pkg;

    typedef logic [1:0] occ_t;

    // A one-phase decimator still needs a 1-bit counter.
    function automatic int cnt_w(input int decim);
        return (decim <= 2) ? 1 : $clog2(decim);
    endfunction

endpackage

// File: rtl/fir_decim_skid.sv
// Two-entry skid FIFO. Upstream ready is registered and never depends on downstream ready.
module fir_decim_skid
    import fir_decim_pkg::*;
#(
    parameter int DATA_WIDTH = 18
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  ready_o,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  ready_i
);

    occ_t                  occ_q, occ_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic                  rdy_q, rdy_d;
    logic                  pop;

    assign pop = (occ_q != 2'd0) && ready_i;

    // push_i is only raised while ready_o is high, so a push never lands on a full FIFO.
    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        case ({push_i, pop})
            2'b10: begin
                if (occ_q == 2'd0) head_d = data_i;
                else               tail_d = data_i;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    head_d = data_i;
                end else begin
                    head_d = tail_q;
                    tail_d = data_i;
                end
            end
            default: ;
        endcase
    end

    assign rdy_d = (occ_d < 2'd2);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            occ_q  <= 2'd0;
            head_q <= '0;
            tail_q <= '0;
            rdy_q  <= 1'b0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
            rdy_q  <= rdy_d;
        end
    end

    assign ready_o = rdy_q;
    assign valid_o = (occ_q != 2'd0);
    assign data_o  = head_q;

endmodule

// File: rtl/fir_decim.sv
// Keep-one-in-DECIM decimator on Avalon-ST, buffered by a 2-entry skid FIFO.
// Optional FIR_DECIM_SYNC_EN adds coe_sync to realign the phase counter.
module fir_decim
    import fir_decim_pkg::*;
#(
    parameter int DATA_WIDTH = 18,
    parameter int DECIM      = 4,
    parameter int PHASE      = 0
) (
    input  logic                         csi_clk,
    input  logic                         rsi_reset_n,
`ifdef FIR_DECIM_SYNC_EN
    input  logic                         coe_sync,
`endif
    input  logic                         asi_din_valid,
    input  logic signed [DATA_WIDTH-1:0] asi_din_data,
    output logic                         asi_din_ready,
    output logic                         aso_dout_valid,
    output logic signed [DATA_WIDTH-1:0] aso_dout_data,
    input  logic                         aso_dout_ready
);

    localparam int             CW      = cnt_w(DECIM);
    localparam logic [CW-1:0]  LAST    = CW'(DECIM - 1);
    localparam logic [CW-1:0]  KEEP_PH = CW'(PHASE);

    if (DECIM < 1 || DECIM > 1024) begin : g_bad_decim
        $error("fir_decim: DECIM=%0d outside 1..1024", DECIM);
    end
    if (PHASE < 0 || PHASE >= DECIM) begin : g_bad_phase
        $error("fir_decim: PHASE=%0d outside 0..DECIM-1", PHASE);
    end

    logic [CW-1:0] phase_q, phase_d, phase_cur;
    logic          din_ready;
    logic          accept;
    logic          keep;

    assign accept = asi_din_valid && din_ready;

`ifdef FIR_DECIM_SYNC_EN
    // A sync pulse makes the beat on the same edge phase 0.
    assign phase_cur = coe_sync ? '0 : phase_q;
`else
    assign phase_cur = phase_q;
`endif

    assign keep = accept && (phase_cur == KEEP_PH);

    always_comb begin
        phase_d = phase_q;
        if (accept) begin
            phase_d = (phase_cur == LAST) ? '0 : phase_cur + 1'b1;
        end
`ifdef FIR_DECIM_SYNC_EN
        else if (coe_sync) begin
            phase_d = '0;
        end
`endif
    end

    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) phase_q <= '0;
        else              phase_q <= phase_d;
    end

    fir_decim_skid #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk_i  (csi_clk),
        .rst_ni (rsi_reset_n),
        .push_i (keep),
        .data_i (asi_din_data),
        .ready_o(din_ready),
        .valid_o(aso_dout_valid),
        .data_o (aso_dout_data),
        .ready_i(aso_dout_ready)
    );

    assign asi_din_ready = din_ready;

endmodule

// File: tb/tb_fir_decim.sv
// Self-checking bench: four decimator configurations against a queue-based reference model.
module tb_fir_decim;

    localparam int N = 4;
    localparam int DEC [N] = '{4, 4, 1, 3};
    localparam int PH  [N] = '{0, 3, 0, 1};

    logic        csi_clk = 1'b0;
    logic        rsi_reset_n;
    logic        vin  [N];
    logic [17:0] din  [N];
    logic        ordy [N];
    logic        syn  [N];
    logic        rdy  [N];
    logic        vout [N];
    logic [17:0] dout [N];

    int checks = 0;
    int errors = 0;

    // reference model state
    int          wr [N] = '{0, 0, 0, 0};
    int          rd [N] = '{0, 0, 0, 0};
    int          idx[N] = '{0, 0, 0, 0};
    int          on [N] = '{0, 0, 0, 0};
    logic        mrdy[N] = '{1'b0, 1'b0, 1'b0, 1'b0};
    logic [17:0] exq [N][2048];
    logic [17:0] olog[N][2048];

    logic        pv [N];
    logic        pr [N];
    logic [17:0] pd [N];

    initial forever #5 csi_clk = ~csi_clk;

    fir_decim #(.DATA_WIDTH(18), .DECIM(4), .PHASE(0)) u_d0 (
        .csi_clk(csi_clk), .rsi_reset_n(rsi_reset_n),
`ifdef FIR_DECIM_SYNC_EN
        .coe_sync(syn[0]),
`endif
        .asi_din_valid(vin[0]), .asi_din_data(din[0]), .asi_din_ready(rdy[0]),
        .aso_dout_valid(vout[0]), .aso_dout_data(dout[0]), .aso_dout_ready(ordy[0]));

    fir_decim #(.DATA_WIDTH(18), .DECIM(4), .PHASE(3)) u_d1 (
        .csi_clk(csi_clk), .rsi_reset_n(rsi_reset_n),
`ifdef FIR_DECIM_SYNC_EN
        .coe_sync(syn[1]),
`endif
        .asi_din_valid(vin[1]), .asi_din_data(din[1]), .asi_din_ready(rdy[1]),
        .aso_dout_valid(vout[1]), .aso_dout_data(dout[1]), .aso_dout_ready(ordy[1]));

    fir_decim #(.DATA_WIDTH(18), .DECIM(1), .PHASE(0)) u_d2 (
        .csi_clk(csi_clk), .rsi_reset_n(rsi_reset_n),
`ifdef FIR_DECIM_SYNC_EN
        .coe_sync(syn[2]),
`endif
        .asi_din_valid(vin[2]), .asi_din_data(din[2]), .asi_din_ready(rdy[2]),
        .aso_dout_valid(vout[2]), .aso_dout_data(dout[2]), .aso_dout_ready(ordy[2]));

    fir_decim #(.DATA_WIDTH(18), .DECIM(3), .PHASE(1)) u_d3 (
        .csi_clk(csi_clk), .rsi_reset_n(rsi_reset_n),
`ifdef FIR_DECIM_SYNC_EN
        .coe_sync(syn[3]),
`endif
        .asi_din_valid(vin[3]), .asi_din_data(din[3]), .asi_din_ready(rdy[3]),
        .aso_dout_valid(vout[3]), .aso_dout_data(dout[3]), .aso_dout_ready(ordy[3]));

    // Model: the n-th accepted beat since reset/sync is kept when n mod DECIM == PHASE;
    // kept beats queue up (at most 2) and leave in order when the sink takes them.
    always @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            for (int i = 0; i < N; i++) begin
                rd[i]   = wr[i];
                idx[i]  = 0;
                mrdy[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                automatic bit acc = vin[i] && mrdy[i];
                automatic int k;
                if (wr[i] != rd[i] && ordy[i]) begin
                    olog[i][on[i] % 2048] = dout[i];
                    on[i]++;
                    rd[i]++;
                end
                if (acc) begin
                    k = syn[i] ? 0 : idx[i];
                    if (k % DEC[i] == PH[i]) begin
                        exq[i][wr[i] % 2048] = din[i];
                        wr[i]++;
                    end
                    idx[i] = k + 1;
                end else if (syn[i]) begin
                    idx[i] = 0;
                end
                mrdy[i] = (wr[i] - rd[i]) < 2;
            end
        end
    end

    task automatic chk(input string nm, input int i, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s dut%0d got %0d exp %0d", nm, i, got, exp);
        end
    endtask

    task automatic cycle_check();
        for (int i = 0; i < N; i++) begin
            if (!rsi_reset_n) begin
                chk("rst_ready", i, int'(rdy[i]), 0);
                chk("rst_valid", i, int'(vout[i]), 0);
                chk("rst_data", i, int'(dout[i]), 0);
            end else begin
                chk("ready", i, int'(rdy[i]), int'(mrdy[i]));
                chk("valid", i, int'(vout[i]), int'(wr[i] != rd[i]));
                if (wr[i] != rd[i])
                    chk("data", i, int'(dout[i]), int'(exq[i][rd[i] % 2048]));
                if (pv[i] && !pr[i] && vout[i])
                    chk("stall_hold", i, int'(dout[i]), int'(pd[i]));
            end
            pv[i] = vout[i] && rsi_reset_n;
            pr[i] = ordy[i];
            pd[i] = dout[i];
        end
    endtask

    task automatic send(input int i, input int d, input bit s);
        bit ok = 1'b0;
        vin[i] = 1'b1;
        din[i] = 18'(d);
        syn[i] = s;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge csi_clk);
            ok = rdy[i];
            @(posedge csi_clk);
            #1;
        end
        vin[i] = 1'b0;
        syn[i] = 1'b0;
        if (!ok) chk("send_timeout", i, 0, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge csi_clk);
        #1;
    endtask

    initial begin
        int beats;
        int b0;
        int b3;
        rsi_reset_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            vin[i] = 1'b0; din[i] = '0; ordy[i] = 1'b1; syn[i] = 1'b0;
            pv[i] = 1'b0; pr[i] = 1'b1; pd[i] = '0;
        end
        fork
            forever begin
                @(negedge csi_clk);
                cycle_check();
            end
        join_none

        idle(3);
        @(posedge csi_clk);
        #2 rsi_reset_n = 1'b1;
        @(posedge csi_clk);
        #1;
        chk("ready_after_rst", 0, int'(rdy[0]), 1);

        // continuous ramp 0..15 into both DECIM=4 instances
        for (int k = 0; k < 16; k++) begin
            vin[0] = 1'b1; vin[1] = 1'b1;
            din[0] = 18'(k); din[1] = 18'(k);
            @(posedge csi_clk);
            #1;
        end
        vin[0] = 1'b0; vin[1] = 1'b0;
        idle(4);
        chk("ph0_count", 0, on[0], 4);
        for (int k = 0; k < 4; k++) chk("ph0_out", 0, int'(olog[0][k]), 4 * k);
        chk("ph3_count", 1, on[1], 4);
        for (int k = 0; k < 4; k++) chk("ph3_out", 1, int'(olog[1][k]), 4 * k + 3);

        // DECIM=1 with the sink stalled: two beats fill the FIFO, third waits
        ordy[2] = 1'b0;
        send(2, 5, 1'b0);
        send(2, 6, 1'b0);
        vin[2] = 1'b1;
        din[2] = 18'd7;
        repeat (3) begin
            @(negedge csi_clk);
            chk("full_ready", 2, int'(rdy[2]), 0);
            @(posedge csi_clk);
            #1;
        end
        chk("stall_nout", 2, on[2], 0);
        ordy[2] = 1'b1;
        send(2, 7, 1'b0);
        idle(4);
        chk("d1_count", 2, on[2], 3);
        for (int k = 0; k < 3; k++) chk("d1_out", 2, int'(olog[2][k]), 5 + k);

        // random valid/ready on DECIM=3, PHASE=1
        beats = 0;
        for (int c = 0; c < 20000 && beats < 1000; c++) begin
            vin[3]  = 1'($urandom_range(0, 1));
            ordy[3] = 1'($urandom_range(0, 1));
            din[3]  = 18'($urandom);
            @(negedge csi_clk);
            if (vin[3] && rdy[3]) beats++;
            @(posedge csi_clk);
            #1;
        end
        vin[3] = 1'b0;
        ordy[3] = 1'b1;
        idle(6);
        chk("rand_beats", 3, beats, 1000);
        chk("rand_outs", 3, on[3], 333);

        // fill two entries, then reset mid-operation
        ordy[0] = 1'b0;
        ordy[3] = 1'b0;
        for (int k = 0; k < 5; k++) send(0, 20 + k, 1'b0);
        for (int k = 0; k < 4; k++) send(3, 40 + k, 1'b0);
        @(negedge csi_clk);
        chk("pre_rst_valid", 0, int'(vout[0]), 1);
        chk("pre_rst_valid", 3, int'(vout[3]), 1);
        chk("pre_rst_ready", 3, int'(rdy[3]), 0);
        @(posedge csi_clk);
        #3 rsi_reset_n = 1'b0;
        #1;
        chk("rst_drop_valid", 0, int'(vout[0]), 0);
        chk("rst_drop_valid", 3, int'(vout[3]), 0);
        repeat (2) @(posedge csi_clk);
        #2 rsi_reset_n = 1'b1;
        ordy[0] = 1'b1;
        ordy[3] = 1'b1;
        b0 = on[0];
        b3 = on[3];
        send(0, 100, 1'b0);
        send(0, 101, 1'b0);
        send(3, 100, 1'b0);
        send(3, 101, 1'b0);
        idle(4);
        chk("post_rst_count", 0, on[0] - b0, 1);
        chk("post_rst_out", 0, int'(olog[0][b0 % 2048]), 100);
        chk("post_rst_count", 3, on[3] - b3, 1);
        chk("post_rst_out", 3, int'(olog[3][b3 % 2048]), 101);

`ifdef FIR_DECIM_SYNC_EN
        // counter sits at phase 2; sync makes input 6 phase 0
        b0 = on[0];
        send(0, 6, 1'b1);
        for (int d = 7; d < 15; d++) send(0, d, 1'b0);
        idle(4);
        chk("sync_count", 0, on[0] - b0, 3);
        for (int k = 0; k < 3; k++) chk("sync_out", 0, int'(olog[0][(b0 + k) % 2048]), 6 + 4 * k);
`endif

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
